// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ADD/SUB/SLT/AND/OR/NOP plus iterative MUL, DIVU and REMU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL and for DIVU/REMU with B!=0.
// Backpressure: start is accepted only in IDLE; it is ignored while busy and in the done cycle.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, OP, A, B   request and its opcode/operands, latched on the accepting edge
//   Res               registered result, held until the next completed operation
//   busy              high while a MUL/DIV iteration is in progress
//   done              one-cycle pulse; Res, zero and div_zero are valid with it
//   zero, div_zero    Res==0, and "DIVU/REMU issued with B==0", both updated with done
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state, state_n;
  logic [3:0]         op_q, op_n;
  logic [WIDTH-1:0]   a_q, a_n;      // MUL: shifting multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0]   b_q, b_n;      // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0]   acc, acc_n;    // MUL: partial product;       DIV: partial remainder
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   res_n;
  logic               zero_n, div_zero_n;
  logic               finish;
  logic [WIDTH-1:0]   finish_val;
  logic               finish_dz;
  logic [WIDTH:0]     shifted, trial;

  // Results that need no iteration. DIVU/REMU only reach here with B==0.
  function automatic logic [WIDTH-1:0] quick_result(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (x < y)};
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_NOP:  return '0;
      OP_DIVU: return '1;
      OP_REMU: return x;
      default: return '0;
    endcase
  endfunction

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

  always_comb begin
    state_n    = state;
    op_n       = op_q;
    a_n        = a_q;
    b_n        = b_q;
    acc_n      = acc;
    cnt_n      = cnt;
    res_n      = Res;
    zero_n     = zero;
    div_zero_n = div_zero;
    finish     = 1'b0;
    finish_val = '0;
    finish_dz  = 1'b0;
    shifted    = '0;
    trial      = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          op_n  = OP;
          a_n   = A;
          b_n   = B;
          acc_n = '0;
          cnt_n = '0;
          if (OP == OP_MUL) begin
            state_n = S_MUL;
          end else if ((OP == OP_DIVU || OP == OP_REMU) && B != '0) begin
            state_n = S_DIV;
          end else begin
            state_n    = S_DONE;
            finish     = 1'b1;
            finish_val = quick_result(OP, A, B);
            finish_dz  = (OP == OP_DIVU || OP == OP_REMU);
          end
        end
      end

      S_MUL: begin
        // Shift-add, multiplier LSB first; bits shifted out of a_q only affect
        // the discarded upper half of the product.
        acc_n = acc + (b_q[0] ? a_q : '0);
        a_n   = a_q << 1;
        b_n   = b_q >> 1;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n    = S_DONE;
          finish     = 1'b1;
          finish_val = acc_n;
        end
      end

      S_DIV: begin
        // Restoring step: bring in the next dividend bit, try to subtract the
        // divisor. trial[WIDTH] set means the subtraction borrowed.
        shifted = {acc, a_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        if (!trial[WIDTH]) begin
          acc_n = trial[WIDTH-1:0];
          a_n   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_n = shifted[WIDTH-1:0];
          a_n   = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_n    = S_DONE;
          finish     = 1'b1;
          finish_val = (op_q == OP_DIVU) ? a_n : acc_n;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Result flags are loaded on the edge that enters DONE so that they are
    // valid in the same cycle as the done pulse.
    if (finish) begin
      res_n      = finish_val;
      zero_n     = (finish_val == '0);
      div_zero_n = finish_dz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      Res      <= '0;
      zero     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      Res      <= res_n;
      zero     <= zero_n;
      div_zero <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: runs the same suite concurrently on a
// WIDTH=32 and a WIDTH=8 instance, comparing against an arithmetic model.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_suite
    localparam int W = (g == 0) ? 32 : 8;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         busy;
    logic         done;
    logic         zero;
    logic         div_zero;
    bit           fin = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .OP(op), .A(a), .B(b),
      .Res(res), .busy(busy), .done(done), .zero(zero), .div_zero(div_zero)
    );

    function automatic logic [63:0] model_res(input logic [3:0] o, input logic [63:0] x,
                                              input logic [63:0] y);
      case (o)
        4'b0010: return (x + y) & MASK;
        4'b0110: return (x - y) & MASK;
        4'b0111: return (x < y) ? 64'd1 : 64'd0;
        4'b0000: return x & y;
        4'b0001: return x | y;
        4'b0011: return (x * y) & MASK;
        4'b0100: return (y == 0) ? MASK : x / y;
        4'b0101: return (y == 0) ? x : x % y;
        default: return 64'd0;
      endcase
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [63:0] y);
      if (o == 4'b0011) return W + 1;
      if ((o == 4'b0100 || o == 4'b0101) && y != 0) return W + 1;
      return 1;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [63:0] x_in, input logic [63:0] y_in);
      logic [63:0] x, y, ex_res;
      logic [W-1:0] held;
      int ex_lat, n, bsy;
      bit held_ok;
      string t;
      x = x_in & MASK;
      y = y_in & MASK;
      ex_res = model_res(o, x, y);
      ex_lat = model_lat(o, y);
      t = $sformatf("w%0d_op%b_%0h_%0h", W, o, x, y);
      held = res;
      held_ok = 1'b1;
      @(negedge clk);
      op = o; a = x[W-1:0]; b = y[W-1:0]; start = 1'b1;
      @(posedge clk); #1;
      n = 1;
      bsy = 0;
      // While busy, throw random ignored requests at the DUT.
      while (!done && n < 4 * W + 8) begin
        if (busy) bsy++;
        if (res !== held) held_ok = 1'b0;
        start = 1'($urandom_range(0, 1));
        op = 4'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        @(posedge clk); #1;
        n++;
      end
      check({t, "_lat"}, 64'(n), 64'(ex_lat));
      check({t, "_res"}, 64'(res), ex_res);
      check({t, "_zero"}, 64'(zero), 64'(ex_res == 0));
      check({t, "_dz"}, 64'(div_zero), 64'((o == 4'b0100 || o == 4'b0101) && y == 0));
      check({t, "_busycyc"}, 64'(bsy), 64'(ex_lat - 1));
      check({t, "_held"}, 64'(held_ok), 64'd1);
      // A start during the done cycle must not be accepted.
      start = 1'b1; op = 4'b0010; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check({t, "_noacc"}, 64'({busy, done}), 64'd0);
      check({t, "_after"}, 64'(res), ex_res);
    endtask

    initial begin
      int dp;
      logic [3:0] ro;
      logic [63:0] rx, ry;
      logic [3:0] valid_ops [9];
      valid_ops = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001,
                    4'b1111, 4'b0011, 4'b0100, 4'b0101};
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      #3;
      check($sformatf("w%0d_rst_state", W), 64'({res, busy, done, zero, div_zero}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(4'b0010, 64'hFFFF_FFFF, 64'd1);
      run_op(4'b0110, 64'd5, 64'd7);
      run_op(4'b0111, 64'hFFFF_FFFF, 64'd1);
      run_op(4'b0111, 64'd1, 64'd2);
      run_op(4'b0011, 64'h0001_0003, 64'h0001_0005);
      run_op(4'b0100, 64'd100, 64'd7);
      run_op(4'b0101, 64'd100, 64'd7);
      run_op(4'b0100, 64'h1234, 64'd0);
      run_op(4'b0101, 64'h1234, 64'd0);
      run_op(4'b0000, 64'hF0F0_A5A5, 64'h0FF0_FFFF);
      run_op(4'b0001, 64'hF000_0001, 64'h0000_0F00);
      run_op(4'b1111, 64'd9, 64'd9);
      run_op(4'b1000, 64'd9, 64'd9);
      run_op(4'b0011, MASK, MASK);
      run_op(4'b0100, MASK, 64'd1);
      run_op(4'b0010, 64'd7, 64'd9);

      // Reset about ten cycles into a MUL: aborts with no done pulse.
      @(negedge clk);
      op = 4'b0011; a = W'(32'h0001_0003); b = W'(32'h0001_0005); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check($sformatf("w%0d_midrst_state", W), 64'({res, busy, done, zero}), 64'd0);
      dp = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2 * W + 4; i++) begin
        @(posedge clk); #1;
        if (done || busy) dp++;
      end
      check($sformatf("w%0d_midrst_quiet", W), 64'(dp), 64'd0);
      run_op(4'b0010, 64'd2, 64'd3);

      for (int i = 0; i < 30; i++) begin
        ro = ($urandom_range(0, 3) == 0) ? 4'($urandom) : valid_ops[$urandom_range(0, 8)];
        rx = {32'($urandom), 32'($urandom)};
        ry = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(0, W - 1);
        run_op(ro, rx, ry);
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && !(g_suite[0].fin && g_suite[1].fin); t++) @(posedge clk);
    check("suites_complete", 64'({g_suite[0].fin, g_suite[1].fin}), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU in the datapath.
- Keeps the existing 4-bit opcode map (ADD, SUB, SLT, AND, OR, NOP).
- Adds iterative unsigned multiply, divide and remainder, using a start/busy/done handshake so the control unit can stall the pipeline.
- All results are registered; the output holds stable until the next completed operation.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- OP  in  4  opcode, latched with start.
- A  in  WIDTH  operand A, latched with start.
- B  in  WIDTH  operand B, latched with start.
- Res  out  WIDTH  registered result.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse; Res is valid in the same cycle.
- zero  out  1  registered (Res==0), updated with done.
- div_zero  out  1  registered; set with done when a DIVU/REMU has B==0, otherwise cleared on every done.

Behaviour:
- Reset, asynchronous: state=IDLE; Res=0, busy=0, done=0, zero=0, div_zero=0; internal operand, accumulator and counter registers cleared.
- Opcodes:
  - 0010 ADD: A+B mod 2^WIDTH.
  - 0110 SUB: A−B mod 2^WIDTH.
  - 0111 SLT: unsigned A<B, result 1 or 0.
  - 0000 AND.
  - 0001 OR.
  - 1111 NOP: result 0.
  - 0011 MUL: low WIDTH bits of unsigned A*B.
  - 0100 DIVU: unsigned floor(A/B).
  - 0101 REMU: unsigned A mod B.
  - All other codes: result 0, latency 1.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 accepts the request: operands and OP are latched.
  - Single-cycle op → DONE; result computed from the latched operands.
  - MUL → state MUL; busy=1, accumulator=0, counter=0.
  - DIVU/REMU with B≠0 → state DIV; busy=1, remainder=0, quotient=A, counter=0.
  - DIVU/REMU with B==0 → DONE; DIVU result = all ones, REMU result = A, div_zero=1.
- MUL: shift-add, one multiplier bit per cycle, LSB first. After WIDTH iterations (counter==WIDTH−1 on the last one) → DONE.
- DIV: restoring division, one quotient bit per cycle, MSB first. After WIDTH iterations → DONE.
- DONE:
  - Res, zero and div_zero are written; done=1 for exactly this cycle; busy=0.
  - Next state is IDLE.
  - start is not accepted in DONE; it is accepted again from the following cycle.
- Latency, accepting edge to done:
  - Single-cycle ops: 1 cycle.
  - MUL, and DIVU/REMU with B≠0: WIDTH+1 cycles.
  - Throughput: at most one op every latency+1 cycles.
- start while busy=1 or in DONE: ignored, no side effects; A, B and OP may change freely.
- Res holds its last value through IDLE, MUL and DIV; it changes only in DONE or on reset.
- Reset asserted mid-MUL or mid-DIV: the operation is aborted, the state returns to IDLE, and no done pulse is issued.
- Wrap-around:
  - ADD/SUB carry and borrow are discarded.
  - MUL upper product bits are discarded; no overflow flag.

Test Plan:
- Reset, then single-cycle ops:
  - ADD A=0xFFFFFFFF, B=1 → Res=0, zero=1, done one cycle after start.
  - SUB 5−7 → Res=0xFFFFFFFE.
- Unsigned SLT: A=0xFFFFFFFF, B=1 → Res=0 (unsigned compare); A=1, B=2 → Res=1; latency 1 each.
- MUL 0x0001_0003 * 0x0001_0005:
  - Res=0x0008_000F, done exactly 33 cycles after start, busy high for 32 cycles.
  - A start pulse mid-operation is ignored and Res is unchanged until done.
- DIVU 100/7 → Res=14; REMU 100/7 → Res=2, div_zero=0; each with latency 33.
- DIVU 0x1234/0 → Res=0xFFFFFFFF, div_zero=1, latency 1; then REMU 0x1234/0 → Res=0x1234, div_zero=1.
- Reset asserted at cycle 10 of a MUL:
  - busy=0, Res=0, no done pulse.
  - A new ADD 2+3 issued after reset release → Res=5.
  - Repeat the full suite with WIDTH=8.
